// File: rtl/sound_seq.sv
// Sound sequencer: plays a short table-driven melody of square-wave notes per trigger code.
// Each note is NOTE_CYC cycles of tone followed by GAP_CYC cycles of silence.
module sound_seq #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned NOTE_CYC = 10000000,
    parameter int unsigned GAP_CYC  = 1000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] sound_code,
    input  logic       play_sound,
    input  logic       mute,
    output logic       pwm,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = 32;

    // Tone half-periods in clk cycles, fixed at elaboration.
    localparam logic [CW-1:0] HP_220  = CW'(CLK_HZ / (2 * 32'd220));
    localparam logic [CW-1:0] HP_262  = CW'(CLK_HZ / (2 * 32'd262));
    localparam logic [CW-1:0] HP_330  = CW'(CLK_HZ / (2 * 32'd330));
    localparam logic [CW-1:0] HP_392  = CW'(CLK_HZ / (2 * 32'd392));
    localparam logic [CW-1:0] HP_440  = CW'(CLK_HZ / (2 * 32'd440));
    localparam logic [CW-1:0] HP_523  = CW'(CLK_HZ / (2 * 32'd523));
    localparam logic [CW-1:0] HP_659  = CW'(CLK_HZ / (2 * 32'd659));
    localparam logic [CW-1:0] HP_784  = CW'(CLK_HZ / (2 * 32'd784));
    localparam logic [CW-1:0] HP_880  = CW'(CLK_HZ / (2 * 32'd880));
    localparam logic [CW-1:0] HP_1047 = CW'(CLK_HZ / (2 * 32'd1047));

    localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Half-period of note idx within the melody for code.
    function automatic logic [CW-1:0] note_hp(input logic [2:0] code, input logic [1:0] idx);
        logic [CW-1:0] hp;
        hp = HP_440;
        case (code)
            3'd1: hp = HP_440;
            3'd2: hp = (idx == 2'd0) ? HP_523 : HP_392;
            3'd3: hp = HP_880;
            3'd4: hp = HP_220;
            3'd5: begin
                case (idx)
                    2'd0:    hp = HP_523;
                    2'd1:    hp = HP_659;
                    2'd2:    hp = HP_784;
                    default: hp = HP_1047;
                endcase
            end
            3'd6: begin
                case (idx)
                    2'd0:    hp = HP_392;
                    2'd1:    hp = HP_330;
                    default: hp = HP_262;
                endcase
            end
            default: hp = HP_440;
        endcase
        return hp;
    endfunction

    // Index of the final note of the melody for code.
    function automatic logic [1:0] last_idx(input logic [2:0] code);
        logic [1:0] li;
        case (code)
            3'd2:    li = 2'd1;
            3'd3:    li = 2'd1;
            3'd5:    li = 2'd3;
            3'd6:    li = 2'd2;
            default: li = 2'd0;
        endcase
        return li;
    endfunction

    state_e        state_q, state_d;
    logic [2:0]    code_q,  code_d;
    logic [1:0]    idx_q,   idx_d;
    logic [CW-1:0] dur_q,   dur_d;
    logic [CW-1:0] half_q,  half_d;
    logic          tone_q,  tone_d;
    logic          pwm_q,   pwm_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic          trig_c;
    logic [CW-1:0] hp_last_c;
    logic          is_last_c;

    assign trig_c    = play_sound && (sound_code != 3'd0) && (sound_code != 3'd7);
    assign hp_last_c = note_hp(code_q, idx_q) - CW'(1);
    assign is_last_c = (idx_q == last_idx(code_q));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            code_q  <= 3'd0;
            idx_q   <= 2'd0;
            dur_q   <= '0;
            half_q  <= '0;
            tone_q  <= 1'b0;
            pwm_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            half_q  <= half_d;
            tone_q  <= tone_d;
            pwm_q   <= pwm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A valid trigger wins over everything, including the final gap edge.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        half_d  = half_q;
        tone_d  = tone_q;
        done_d  = 1'b0;

        if (trig_c) begin
            state_d = ST_NOTE;
            code_d  = sound_code;
            idx_d   = 2'd0;
            dur_d   = '0;
            half_d  = '0;
            tone_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dur_d  = '0;
                    half_d = '0;
                    tone_d = 1'b0;
                end
                ST_NOTE: begin
                    if (dur_q == NOTE_LAST) begin
                        state_d = ST_GAP;
                        dur_d   = '0;
                        half_d  = '0;
                        tone_d  = 1'b0;
                    end else begin
                        dur_d = dur_q + CW'(1);
                        if (half_q == hp_last_c) begin
                            half_d = '0;
                            tone_d = ~tone_q;
                        end else begin
                            half_d = half_q + CW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    tone_d = 1'b0;
                    half_d = '0;
                    if (dur_q == GAP_LAST) begin
                        dur_d = '0;
                        if (is_last_c) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_NOTE;
                            idx_d   = idx_q + 2'd1;
                        end
                    end else begin
                        dur_d = dur_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dur_d   = '0;
                    half_d  = '0;
                    tone_d  = 1'b0;
                end
            endcase
        end
    end

    // Mute only gates the output; the tone generator keeps running underneath.
    always_comb begin
        pwm_d  = tone_d && !mute;
        busy_d = (state_d != ST_IDLE);
    end

    assign pwm  = pwm_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/sound_seq.md
SOUND_SEQ -- requirements
Module: sound_seq

Interface
REQ-001 Parameter CLK_HZ, default 100000000, meaning clock frequency in Hz, used to derive tone half-periods.
REQ-002 Parameter NOTE_CYC, default 10000000, meaning length of each note in clk cycles (100 ms).
REQ-003 Parameter GAP_CYC, default 1000000, meaning silent gap after each note in clk cycles (10 ms).
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 sound_code  input  3  sound to play, sampled only while play_sound=1.
REQ-007 play_sound  input  1  trigger, single-cycle pulse from the game logic stage.
REQ-008 mute  input  1  1 forces pwm low without affecting sequencing.
REQ-009 pwm  output  1  square-wave tone to the audio output.
REQ-010 busy  output  1  1 while a sequence is playing.
REQ-011 done  output  1  one-cycle pulse when a sequence completes normally.

Function
REQ-012 The sound table SHALL be: code 0 none; 1 move {440 Hz}; 2 capture {523, 392}; 3 check {880, 880}; 4 invalid {220}; 5 win {523, 659, 784, 1047}; 6 lose {392, 330, 262}; 7 reserved.
REQ-013 Each note's half-period SHALL be CLK_HZ/(2*freq) cycles, integer division, computed at elaboration; counters SHALL be 32 bits wide.
REQ-014 The FSM SHALL have states IDLE, NOTE and GAP.
REQ-015 In IDLE, a play_sound=1 with code 1-6 SHALL latch the code, set note index 0, clear all counters and enter NOTE on that edge; busy SHALL read 1 from the next cycle.
REQ-016 play_sound with code 0 or 7 SHALL be ignored in every state.
REQ-017 In NOTE, a duration counter SHALL count NOTE_CYC cycles, after which the FSM SHALL enter GAP.
REQ-018 In GAP, the FSM SHALL count GAP_CYC cycles, then enter NOTE for the next note if one remains, else enter IDLE.
REQ-019 done SHALL be 1 for exactly the cycle after the GAP-to-IDLE transition edge, i.e. the first IDLE cycle.
REQ-020 Tone generation: pwm SHALL be 0 on NOTE entry and SHALL toggle whenever the half-period counter reaches half-period-1; that counter SHALL then wrap to 0.
REQ-021 pwm SHALL be 0 in IDLE and GAP.
REQ-022 pwm SHALL be 0 whenever mute=1; mute SHALL NOT alter the state, counters or done.
REQ-023 A valid play_sound while busy SHALL pre-empt: restart at note 0 of the new code from NOTE, with counters cleared and pwm 0; no done pulse for the aborted sequence.
REQ-024 A valid play_sound coinciding with the final GAP-to-IDLE edge SHALL pre-empt; done SHALL NOT pulse.
REQ-025 busy SHALL be 1 exactly when the state is NOTE or GAP.

Reset
REQ-026 rstn=0 SHALL immediately force IDLE, pwm=0, busy=0 and done=0, and clear all counters, the note index and the latched code, including mid-sequence.
REQ-027 After rstn rises, the block SHALL accept a trigger on the first clock edge.

Verification (CLK_HZ=8800, NOTE_CYC=100, GAP_CYC=10; 440 Hz half-period = 10 cycles)
REQ-028 Code 1 pulse -> busy=1 for 110 cycles; pwm rises after 10 cycles and has period 20 for 100 cycles; then GAP low for 10; done one cycle; busy=0.
REQ-029 Code 5 pulse -> four notes with half-periods 8, 6, 5, 4 cycles; busy for 440 cycles; a single done at the end.
REQ-030 Code 2 pulse, then code 4 pulse 50 cycles later -> sequence restarts at 220 Hz (half-period 20); busy lasts 110 cycles after the second pulse; exactly one done.
REQ-031 Code 0 or 7 pulse in IDLE -> busy, pwm and done stay 0; the same pulse during a code 3 sequence leaves it unchanged.
REQ-032 Code 6 with mute=1 throughout -> pwm constantly 0; busy for 330 cycles; done pulses once.
REQ-033 rstn low for 3 cycles mid-note during code 5 -> pwm, busy and done are 0 asynchronously; IDLE holds after release; a new code 1 pulse plays normally.
